// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Drives a 4-digit multiplexed common-electrode 7-segment display with the
// 16-bit hex word from the keypad scanner (digit 0 = data[3:0] = rightmost).
//
// - A word strobed in on 'load' is held pending.
// - It is committed to the display only when the digit index wraps 3->0,
//   so a frame never shows a mix of old and new digits.
// - Every digit slot opens with DEAD_CYC blank cycles to prevent ghosting.
//
// Optional build macro:
//   SEG7_LZB_EN  leading-zero blanking. Digit i>0 is blanked while nibbles
//                i..3 are all zero. Digit 0 is never blanked by this rule.
//
// Ports:
//   clk         in   system clock
//   clr         in   asynchronous active-high reset
//   load        in   1-cycle strobe, captures {dp_in,data} as the pending word
//   data[15:0]  in   hex word; nibble i drives digit i
//   dp_in[3:0]  in   decimal point per digit, 1 = lit
//   digit_en    in   per-digit enable, sampled live; 0 = digit always blank
//   seg[6:0]    out  segments {g,f,e,d,c,b,a}
//   dp          out  decimal point of the selected digit
//   dig_sel     out  one-hot digit select
//   upd_pend    out  a loaded word is waiting for the next frame boundary
//   frame_done  out  1-cycle pulse after every 3->0 wrap of the digit index
//
// Valid/ready: load is a fire-and-forget strobe with no backpressure. A load
// while a word is already pending overwrites it (last value wins).
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYC       = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_sel,
    output logic        upd_pend,
    output logic        frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYC);
    localparam logic [6:0]    SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic          DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0]    DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   disp, disp_nxt, pend, pend_nxt;
    logic [3:0]    disp_dp, disp_dp_nxt, pend_dp, pend_dp_nxt;
    logic          upd_pend_nxt, frame_done_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    dig_sel_nxt;
    logic          tick, wrap, commit, lzb, dig_blank;
    logic [3:0]    nib;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h3F;  4'h1: font = 7'h06;
            4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
            4'h4: font = 7'h66;  4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;  4'h7: font = 7'h07;
            4'h8: font = 7'h7F;  4'h9: font = 7'h6F;
            4'hA: font = 7'h77;  4'hB: font = 7'h7C;
            4'hC: font = 7'h39;  4'hD: font = 7'h5E;
            4'hE: font = 7'h79;  default: font = 7'h71;
        endcase
    endfunction

    always_comb begin
        tick     = (cnt == CNT_LAST);
        wrap     = tick && (idx == 2'd3);
        // Commit takes the word pending *before* this edge; a load on the
        // same edge only refills pend.
        commit   = wrap && upd_pend;
        cnt_nxt  = tick ? '0 : cnt + CW'(1);
        idx_nxt  = tick ? idx + 2'd1 : idx;

        state_nxt = state;
        case (state)
            BLANK: if (cnt_nxt == DEAD_END) state_nxt = DRIVE;
            DRIVE: if (tick) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase

        disp_nxt       = commit ? pend : disp;
        disp_dp_nxt    = commit ? pend_dp : disp_dp;
        pend_nxt       = load ? data : pend;
        pend_dp_nxt    = load ? dp_in : pend_dp;
        upd_pend_nxt   = load ? 1'b1 : (commit ? 1'b0 : upd_pend);
        frame_done_nxt = wrap;

        // Outputs are registered, so decode from next-cycle values to keep
        // seg/dig_sel aligned with the cnt/idx they belong to.
        nib = disp_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
        case (idx_nxt)
            2'd3:    lzb = (disp_nxt[15:12] == 4'h0);
            2'd2:    lzb = (disp_nxt[15:8]  == 8'h00);
            2'd1:    lzb = (disp_nxt[15:4]  == 12'h000);
            default: lzb = 1'b0;
        endcase
`else
        lzb = 1'b0;
`endif
        dig_blank = !digit_en[idx_nxt] || lzb;

        seg_nxt     = SEG_OFF;
        dp_nxt      = DP_OFF;
        dig_sel_nxt = DIG_OFF;
        if (state_nxt == DRIVE) begin
            // A blanked digit keeps its select asserted; only seg/dp go dark.
            dig_sel_nxt = DIG_OFF ^ (4'b0001 << idx_nxt);
            if (!dig_blank) begin
                seg_nxt = SEG_OFF ^ font(nib);
                dp_nxt  = DP_OFF ^ disp_dp_nxt[idx_nxt];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            disp_dp    <= 4'h0;
            pend       <= 16'h0000;
            pend_dp    <= 4'h0;
            upd_pend   <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig_sel    <= DIG_OFF;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            disp       <= disp_nxt;
            disp_dp    <= disp_dp_nxt;
            pend       <= pend_nxt;
            pend_dp    <= pend_dp_nxt;
            upd_pend   <= upd_pend_nxt;
            frame_done <= frame_done_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            dig_sel    <= dig_sel_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Bench for seg7_scan_driver with CLK_DIV=4, DEAD_CYC=1, active-low segments
// and digits. The expected outputs after edge k (counted from reset release)
// come from a timeline: slot = (k/4)%4, phase = k%4, blank when phase == 0,
// and frame boundaries at k%16 == 0, where a pending word is committed.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic        upd_pend;
    logic        frame_done;

    seg7_scan_driver #(
        .CLK_DIV(4), .DEAD_CYC(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .clr(clr), .load(load), .data(data), .dp_in(dp_in),
        .digit_en(digit_en), .seg(seg), .dp(dp), .dig_sel(dig_sel),
        .upd_pend(upd_pend), .frame_done(frame_done)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard state
    logic [13:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // reference timeline state
    int          k = 0;
    logic [15:0] m_disp = 16'h0, m_pend = 16'h0;
    logic [3:0]  m_dp = 4'h0, m_pend_dp = 4'h0;
    logic        m_pv = 1'b0;

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                  7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                  7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {seg,dp,dig_sel,upd_pend,frame_done} after edge k.
    function automatic logic [13:0] expect_vec();
        int         slot, phase;
        logic [6:0] e_seg;
        logic       e_dp, blank;
        logic [3:0] e_dig, nib;
        slot  = (k / 4) % 4;
        phase = k % 4;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_dig = 4'hF;
        if (phase != 0) begin
            e_dig = ~(4'b0001 << slot);
            nib   = 4'((m_disp >> (4 * slot)) & 16'hF);
            blank = !digit_en[slot];
`ifdef SEG7_LZB_EN
            if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) blank = 1'b1;
`endif
            if (!blank) begin
                e_seg = ~font_tab[nib];
                e_dp  = ~m_dp[slot];
            end
        end
        return {e_seg, e_dp, e_dig, m_pv, (k % 16 == 0)};
    endfunction

    // One clock cycle: drive inputs, advance the timeline, push expectation,
    // then compare after the edge.
    task automatic step(input logic ld, input logic [15:0] d,
                        input logic [3:0] dpi);
        logic commit;
        load  = ld;
        data  = d;
        dp_in = dpi;
        k++;
        commit = (k % 16 == 0) && m_pv;
        if (commit) begin
            m_disp = m_pend;
            m_dp   = m_pend_dp;
        end
        if (ld) begin
            m_pend    = d;
            m_pend_dp = dpi;
            m_pv      = 1'b1;
        end else if (commit) begin
            m_pv = 1'b0;
        end
        exp_q.push_back(expect_vec());
        @(posedge clk);
        #1;
        load = 1'b0;
        check_eq($sformatf("out_k%0d", k),
                 {18'h0, seg, dp, dig_sel, upd_pend, frame_done},
                 {18'h0, exp_q.pop_front()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, data, dp_in);
    endtask

    task automatic reset_model();
        k = 0; m_disp = 16'h0; m_dp = 4'h0; m_pv = 1'b0;
    endtask

    task automatic check_inactive(input string tag);
        check_eq({tag, "_seg"},  {25'h0, seg}, 32'h7F);
        check_eq({tag, "_dp"},   {31'h0, dp}, 32'h1);
        check_eq({tag, "_dig"},  {28'h0, dig_sel}, 32'hF);
        check_eq({tag, "_pend"}, {31'h0, upd_pend}, 32'h0);
        check_eq({tag, "_fd"},   {31'h0, frame_done}, 32'h0);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        check_inactive("reset");
        @(negedge clk);
        clr = 1'b0;
        reset_model();

        // 1: idle scan of 0000
        idle(40);

        // 2: mid-frame load of 12AF with one decimal point
        step(1'b1, 16'h12AF, 4'b0010);
        idle(40);

        // 3: overwrite a pending word before the wrap
        step(1'b1, 16'h1111, 4'h0);
        idle(3);
        step(1'b1, 16'h2222, 4'h0);
        idle(36);

        // 4: load exactly on the wrap-tick edge with nothing pending
        while (m_pv) idle(1);
        while ((k + 1) % 16 != 0) idle(1);
        step(1'b1, 16'h3C5D, 4'b1001);
        idle(36);

        // 5: digit enables with 8888
        step(1'b1, 16'h8888, 4'hF);
        while (m_pv) idle(1);
        digit_en = 4'b0101;
        idle(20);
        digit_en = 4'hF;

        // random loads, enables and gaps
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            digit_en = 4'($urandom_range(0, 15));
            idle($urandom_range(1, 30));
        end
        digit_en = 4'hF;

        // 6: leading zeros, then clr in the middle of a slot
        step(1'b1, 16'h0040, 4'h0);
        idle(36);
        step(1'b1, 16'h0007, 4'h1);
        idle(2);
        #2;
        clr = 1'b1;
        #1;
        check_inactive("clr_mid");
        @(negedge clk);
        clr = 1'b0;
        reset_model();
        idle(36);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
